// File: rtl/mix_unround.sv
// Inverse of the 8-word x 32-bit mixing round: undoes ROUNDS rounds with one word update per clock.
// Optional MIX_UNROUND_COUNT_EN adds a 32-bit done_count output counting output handshakes.
module mix_unround #(
   parameter int unsigned ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [255:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_data
`ifdef MIX_UNROUND_COUNT_EN
   ,
   output logic [31:0]  done_count
`endif
);

   // state    | meaning
   // ST_IDLE  | ready for a new mixed state
   // ST_RUN   | applying one inverse step per cycle
   // ST_DONE  | recovered state presented until out_ready
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] STG_C = 2'd0;
   localparam logic [1:0] STG_B = 2'd1;
   localparam logic [1:0] STG_A = 2'd2;

   localparam logic [7:0] LAST_RND = 8'(ROUNDS - 1);

   logic [1:0]  state_q, state_d;
   logic [31:0] words_q [8];
   logic [31:0] words_d [8];
   logic [7:0]  round_q, round_d;
   logic [1:0]  stage_q, stage_d;
   logic [2:0]  idx_q, idx_d;

   logic [2:0]  idx_p1, idx_p2, idx_p3, idx_p4, idx_p5;
   logic [31:0] upd;

   // neighbour indices wrap naturally in 3 bits
   assign idx_p1 = idx_q + 3'd1;
   assign idx_p2 = idx_q + 3'd2;
   assign idx_p3 = idx_q + 3'd3;
   assign idx_p4 = idx_q + 3'd4;
   assign idx_p5 = idx_q + 3'd5;

   always_comb begin
      upd = words_q[idx_q];
      case (stage_q)
         STG_C:   upd = words_q[idx_q] + (words_q[idx_p2] >> 17) - (words_q[idx_p4] >> 12);
         STG_B:   upd = words_q[idx_q] ^ (words_q[idx_p3] << 16);
         default: upd = words_q[idx_q] - words_q[idx_p1] + words_q[idx_p5];
      endcase
   end

   always_comb begin
      state_d = state_q;
      words_d = words_q;
      round_d = round_q;
      stage_d = stage_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               for (int i = 0; i < 8; i++) begin
                  words_d[i] = in_data[32*i +: 32];
               end
               round_d = 8'd0;
               stage_d = STG_C;
               idx_d   = 3'd7;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            words_d[idx_q] = upd;
            idx_d          = idx_q - 3'd1;
            if (idx_q == 3'd0) begin
               if (stage_q == STG_A) begin
                  stage_d = STG_C;
                  round_d = round_q + 8'd1;
                  if (round_q == LAST_RND) begin
                     state_d = ST_DONE;
                  end
               end else begin
                  stage_d = stage_q + 2'd1;
               end
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         words_q <= '{default: 32'd0};
         round_q <= 8'd0;
         stage_q <= 2'd0;
         idx_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         words_q <= words_d;
         round_q <= round_d;
         stage_q <= stage_d;
         idx_q   <= idx_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);

   always_comb begin
      out_data = '0;
      for (int i = 0; i < 8; i++) begin
         out_data[32*i +: 32] = words_q[i];
      end
   end

`ifdef MIX_UNROUND_COUNT_EN
   logic [31:0] done_count_q, done_count_d;

   assign done_count_d = (out_valid && out_ready) ? done_count_q + 32'd1 : done_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         done_count_q <= 32'd0;
      end else begin
         done_count_q <= done_count_d;
      end
   end

   assign done_count = done_count_q;
`endif

endmodule

// File: doc/mix_unround.md
Name: mix_unround

Overview:
- Inverse of the 8-word, 32-bit mixing round used by the clocked mixer datapath.
- Accepts one 256-bit mixed state and undoes ROUNDS rounds, one word update per clock.
- Returns the original pre-mix state.
- Sits downstream of the mixer, or on the receive side of a mixed link, as its decoder.

Parameters:
- ROUNDS, 10, number of forward rounds to undo; legal range 1..255.

Ports:
- clk  input  1  single clock, all state updates on posedge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  in_data holds a mixed state
- in_ready  output  1  block can accept a state
- in_data  input  256  mixed state; word i = bits [32i+31:32i], i=0..7
- out_valid  output  1  out_data holds the recovered state
- out_ready  input  1  consumer accepts out_data
- out_data  output  256  recovered state, same packing as in_data

Behaviour:
- All arithmetic is mod 2^32. Shifts are logical. Indices are mod 8.
- Forward round (normative definition) has three stages. Within each stage, i runs 0..7 sequentially, and each step sees the results of earlier steps:
  - A: w[i] = w[i] + w[i+1] - w[i+5]
  - B: w[i] = w[i] ^ (w[i+3] << 16)
  - C: w[i] = w[i] - (w[i+2] >> 17) + (w[i+4] >> 12)
- Inverse round, stages in order C', B', A', each with i running 7 down to 0:
  - C': w[i] = w[i] + (w[i+2] >> 17) - (w[i+4] >> 12)
  - B': w[i] = w[i] ^ (w[i+3] << 16)
  - A': w[i] = w[i] - w[i+1] + w[i+5]
- Each step reads only words other than w[i]. This makes the step exact and lossless.
- Exactly one word update per clock.
- Internal state:
  - 8x32 word register
  - round counter, 8 bits
  - stage counter: C' / B' / A'
  - index counter, 3 bits, counting down
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, load words, set round=0, stage=C', index=7, go to RUN.
  - RUN: in_ready=0, out_valid=0. Apply one step per cycle. When index=0, wrap index to 7 and advance the stage. After A' with index=0, increment round. After A' index=0 of round ROUNDS-1, go to DONE.
  - DONE: out_valid=1, out_data=word register, held stable. On out_valid&&out_ready, go to IDLE.
- Latency:
  - Input accepted at edge k.
  - 24*ROUNDS update edges follow.
  - out_valid goes high after edge k+24*ROUNDS.
- Throughput: one state per 24*ROUNDS+2 cycles minimum.
  - There is no same-cycle turnaround: in_ready rises the cycle after the output handshake.
- Backpressure: with out_ready low, DONE holds indefinitely. out_data is unchanged and in_ready stays 0.
- in_valid while not in IDLE is ignored. There is no requirement that the producer hold in_data after the handshake.
- Reset values:
  - in_ready=1 after reset (IDLE)
  - out_valid=0
  - out_data=0 (word register cleared)
  - round, stage and index counters all 0
- Reset mid-operation (RUN or DONE): abandon the current state, return to IDLE next cycle, no output produced.
- rst has priority over every handshake in the same cycle.

Optional Feature:
- Macro MIX_UNROUND_COUNT_EN.
- Defined:
  - Adds an output port done_count, 32 bits.
  - Reset to 0.
  - Increments by 1 on each out_valid&&out_ready handshake; wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- All-zero: ROUNDS=10, in_data=0 → out_data=0; out_valid is first high 240 cycles after the accept edge.
- Round-trip: ROUNDS=10. Bench forward model mixes words {0,1,2,3,4,5,6,7} and the result is fed in → out_data words equal 0..7 exactly.
  - Repeat with 200 random vectors; all must match.
- Boundary ROUNDS=1: word i=0x80000000+i round-trips correctly; latency is 24 cycles.
  - in_ready is 0 for cycles 1..24 and during DONE.
- Backpressure: hold out_ready=0 for 50 cycles after out_valid.
  - out_data stays constant.
  - in_valid pulses during that window are ignored.
  - out_ready=1 → one handshake, then in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst at update cycle 100 of 240 → next cycle in_ready=1, out_valid=0, out_data=0. A new accepted vector then decodes correctly.
- With MIX_UNROUND_COUNT_EN: run 3 decodes → done_count=3.
  - Force the counter to 0xFFFFFFFF, then run one decode → done_count=0.
